rf_dump: RTL and testbench

RF_DUMP -- requirements
Module: rf_dump

---
 rtl/rf_dump_pkg.sv | 15 +
 rtl/rf_dump.sv | 119 +++++++++++
 tb/tb_rf_dump.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_dump_pkg.sv
// Shared register-file definitions for the dump engine: geometry defaults
// and the dump FSM state encoding.
package rf_dump_pkg;

  localparam int RF_AW = 3;
  localparam int RF_DW = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_FIN   = 2'd3
  } dump_state_t;

endpackage

// File: rtl/rf_dump.sv
// Sequential register-file dump engine: reads count entries starting at
// start_addr (wrapping), presenting each on a valid/ready output port.
module rf_dump
  import rf_dump_pkg::*;
#(
  parameter int AW = RF_AW,
  parameter int DW = RF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW:0]   count,
  input  logic          abort,
  output logic [AW-1:0] rf_addr,
  input  logic [DW-1:0] rf_dout,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_idx,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  dump_state_t   state_q, state_d;
  logic [AW-1:0] cur_addr_q, cur_addr_d;
  logic [AW:0]   remaining_q, remaining_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [AW-1:0] out_idx_q, out_idx_d;
  logic          out_valid_q;
  logic          busy_q;
  logic          done_q;

  // Next-state logic; abort wins over a simultaneous SEND handshake.
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (count != '0) begin
            cur_addr_d  = start_addr;
            remaining_d = count;
            state_d     = ST_FETCH;
          end else begin
            state_d = ST_FIN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          out_data_d = rf_dout;
          out_idx_d  = cur_addr_q;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (out_ready) begin
          if (remaining_q == (AW+1)'(1)) begin
            state_d = ST_FIN;
          end else begin
            cur_addr_d  = cur_addr_q + AW'(1);
            remaining_d = remaining_q - (AW+1)'(1);
            state_d     = ST_FETCH;
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; status flags are decoded from the next state
  // so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= (state_d == ST_SEND);
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= (state_d == ST_FIN);
    end
  end

  assign rf_addr   = cur_addr_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_rf_dump.sv
// Directed bench for rf_dump with a behavioural 8x8 register file that is
// written on the falling edge and read combinationally.
module tb_rf_dump;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] start_addr;
  logic [3:0] count;
  logic       abort;
  logic [2:0] rf_addr;
  logic [7:0] rf_dout;
  logic [7:0] out_data;
  logic [2:0] out_idx;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;

  logic [7:0] rf_mem [8];

  int tests_run;
  int tests_failed;

  logic [7:0] cap_data[$];
  logic [2:0] cap_idx[$];
  int         cap_cyc[$];
  logic [7:0] stall_data[$];
  int         done_cnt;
  int         done_cyc;

  rf_dump #(.AW(3), .DW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .count      (count),
    .abort      (abort),
    .rf_addr    (rf_addr),
    .rf_dout    (rf_dout),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done)
  );

  assign rf_dout = rf_mem[rf_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Start pulse sampled by the next rising edge; returns at cycle 1's negedge.
  task automatic do_start(input logic [2:0] sa, input logic [3:0] cnt);
    start      = 1'b1;
    start_addr = sa;
    count      = cnt;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs max_cyc cycles recording handshakes and done pulses; holds ready low
  // for the first stall_n valid cycles and rewrites RF[0] during that stall.
  task automatic collect(input int max_cyc, input int stall_n);
    int stall_left;
    stall_left = stall_n;
    cap_data.delete(); cap_idx.delete(); cap_cyc.delete(); stall_data.delete();
    done_cnt = 0;
    done_cyc = -1;
    for (int c = 1; c <= max_cyc; c++) begin
      if (out_valid && stall_left > 0) begin
        out_ready = 1'b0;
        stall_data.push_back(out_data);
        if (stall_left == stall_n - 1) rf_mem[0] = 8'hAA;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        cap_data.push_back(out_data);
        cap_idx.push_back(out_idx);
        cap_cyc.push_back(c);
      end
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    tests_run++;
    if ({rf_addr, out_data, out_idx, out_valid, busy, done} !== 17'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h expected 0", {rf_addr, out_data, out_idx, out_valid, busy, done});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_full();
    do_start(3'd0, 4'd8);
    collect(20, 0);
    tests_run++;
    if (cap_data.size() != 8) begin
      tests_failed++;
      $display("FAIL full_count: got %0d entries expected 8", cap_data.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        tests_run++;
        if (cap_data[k] !== 8'h10 + k[7:0] || cap_idx[k] !== k[2:0] || cap_cyc[k] != 2*k + 2) begin
          tests_failed++;
          $display("FAIL full_entry%0d: got data %h idx %0d cyc %0d expected %h %0d %0d",
                   k, cap_data[k], cap_idx[k], cap_cyc[k], 8'h10 + k[7:0], k, 2*k + 2);
        end
      end
    end
    tests_run++;
    if (done_cnt != 1 || done_cyc != 17) begin
      tests_failed++;
      $display("FAIL full_done: got %0d pulses at cycle %0d expected 1 at 17", done_cnt, done_cyc);
    end
  endtask

  task automatic test_wrap();
    logic [2:0] exp_idx [4];
    exp_idx[0] = 3'd6; exp_idx[1] = 3'd7; exp_idx[2] = 3'd0; exp_idx[3] = 3'd1;
    do_start(3'd6, 4'd4);
    collect(11, 0);
    tests_run++;
    if (cap_data.size() != 4) begin
      tests_failed++;
      $display("FAIL wrap_count: got %0d entries expected 4", cap_data.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        tests_run++;
        if (cap_idx[k] !== exp_idx[k] || cap_data[k] !== 8'h10 + {5'd0, exp_idx[k]}) begin
          tests_failed++;
          $display("FAIL wrap_entry%0d: got idx %0d data %h expected %0d %h",
                   k, cap_idx[k], cap_data[k], exp_idx[k], 8'h10 + {5'd0, exp_idx[k]});
        end
      end
    end
    tests_run++;
    if (done_cnt != 1 || done_cyc != 9) begin
      tests_failed++;
      $display("FAIL wrap_done: got %0d pulses at cycle %0d expected 1 at 9", done_cnt, done_cyc);
    end
  endtask

  task automatic test_backpressure();
    do_start(3'd0, 4'd3);
    collect(14, 5);
    rf_mem[0] = 8'h10;
    tests_run++;
    if (stall_data.size() != 5) begin
      tests_failed++;
      $display("FAIL stall_len: got %0d stalled cycles expected 5", stall_data.size());
    end
    foreach (stall_data[k]) begin
      tests_run++;
      if (stall_data[k] !== 8'h10) begin
        tests_failed++;
        $display("FAIL stall_hold%0d: got %h expected 10", k, stall_data[k]);
      end
    end
    tests_run++;
    if (cap_data.size() != 3) begin
      tests_failed++;
      $display("FAIL stall_count: got %0d entries expected 3", cap_data.size());
    end else begin
      tests_run++;
      if ({cap_data[0], cap_data[1], cap_data[2]} !== 24'h101112 ||
          {cap_idx[0], cap_idx[1], cap_idx[2]} !== 9'o012) begin
        tests_failed++;
        $display("FAIL stall_seq: got %h %h %h expected 10 11 12", cap_data[0], cap_data[1], cap_data[2]);
      end
    end
    tests_run++;
    if (done_cnt != 1 || done_cyc != 12) begin
      tests_failed++;
      $display("FAIL stall_done: got %0d pulses at cycle %0d expected 1 at 12", done_cnt, done_cyc);
    end
  endtask

  task automatic test_zero_count();
    do_start(3'd5, 4'd0);
    collect(4, 0);
    tests_run++;
    if (done_cnt != 1 || done_cyc != 1 || cap_data.size() != 0) begin
      tests_failed++;
      $display("FAIL zero_count: got %0d pulses at %0d with %0d entries expected 1 at 1 with 0",
               done_cnt, done_cyc, cap_data.size());
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_idle: got busy %b expected 0", busy);
    end
  endtask

  task automatic test_abort();
    int n_hs;
    n_hs = 0;
    do_start(3'd0, 4'd8);
    for (int c = 1; c < 6; c++) begin
      if (out_valid) n_hs++;
      @(negedge clk);
    end
    tests_run++;
    if (out_valid !== 1'b1 || out_idx !== 3'd2 || n_hs != 2) begin
      tests_failed++;
      $display("FAIL abort_pre: got valid %b idx %0d hs %0d expected 1 2 2", out_valid, out_idx, n_hs);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_exit: got busy %b valid %b done %b expected 0 0 0", busy, out_valid, done);
    end
    collect(3, 0);
    tests_run++;
    if (done_cnt != 0 || cap_data.size() != 0) begin
      tests_failed++;
      $display("FAIL abort_quiet: got %0d done %0d entries expected 0 0", done_cnt, cap_data.size());
    end
    do_start(3'd2, 4'd2);
    collect(6, 0);
    tests_run++;
    if (cap_data.size() != 2 || done_cnt != 1) begin
      tests_failed++;
      $display("FAIL abort_restart: got %0d entries %0d done expected 2 1", cap_data.size(), done_cnt);
    end else begin
      tests_run++;
      if ({cap_data[0], cap_data[1]} !== 16'h1213 || {cap_idx[0], cap_idx[1]} !== 6'o23) begin
        tests_failed++;
        $display("FAIL abort_restart_data: got %h %h expected 12 13", cap_data[0], cap_data[1]);
      end
    end
  endtask

  task automatic test_rst_mid();
    int n_hs;
    n_hs = 0;
    do_start(3'd0, 4'd8);
    for (int c = 1; c < 7; c++) begin
      if (c == 3) begin
        start      = 1'b1;
        start_addr = 3'd5;
        count      = 4'd1;
      end else begin
        start = 1'b0;
      end
      if (out_valid) begin
        tests_run++;
        if (out_idx !== n_hs[2:0] || out_data !== 8'h10 + n_hs[7:0]) begin
          tests_failed++;
          $display("FAIL busy_start_entry%0d: got idx %0d data %h expected %0d %h",
                   n_hs, out_idx, out_data, n_hs, 8'h10 + n_hs[7:0]);
        end
        n_hs++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || out_valid !== 1'b0 || rf_addr !== 3'd3 || n_hs != 3) begin
      tests_failed++;
      $display("FAIL rst_fetch3: got busy %b valid %b addr %0d hs %0d expected 1 0 3 3",
               busy, out_valid, rf_addr, n_hs);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({rf_addr, out_data, out_idx, out_valid, busy, done} !== 17'd0) begin
      tests_failed++;
      $display("FAIL rst_async: got %h expected 0", {rf_addr, out_data, out_idx, out_valid, busy, done});
    end
    @(negedge clk);
    rst = 1'b0;
    do_start(3'd4, 4'd2);
    collect(6, 0);
    tests_run++;
    if (cap_data.size() != 2 || done_cnt != 1 || done_cyc != 5) begin
      tests_failed++;
      $display("FAIL rst_restart: got %0d entries %0d done at %0d expected 2 1 at 5",
               cap_data.size(), done_cnt, done_cyc);
    end else begin
      tests_run++;
      if ({cap_data[0], cap_data[1]} !== 16'h1415 || {cap_idx[0], cap_idx[1]} !== 6'o45) begin
        tests_failed++;
        $display("FAIL rst_restart_data: got %h %h expected 14 15", cap_data[0], cap_data[1]);
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst        = 1'b1;
    start      = 1'b0;
    start_addr = 3'd0;
    count      = 4'd0;
    abort      = 1'b0;
    out_ready  = 1'b1;
    for (int i = 0; i < 8; i++) rf_mem[i] = 8'h10 + i[7:0];
    @(negedge clk);
    test_reset();
    test_full();
    test_wrap();
    test_backpressure();
    test_zero_count();
    test_abort();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
